mem_lsu: RTL and testbench
==========================

# mem_lsu

Memory-stage load/store unit. It consumes the decoded load/store fields and the computed address from the EXU→MEM pipeline register, runs one request/response transaction per memory instruction on the data-cache port, and stalls that register while the access is outstanding. Load results are aligned and sign- or zero-extended, then presented on `load_data` as the `opload_read_data_wb` value for the MEM→WB stage.

## Interface
- `DATA_WIDTH`, 64, width of data bus, addresses and results.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  MEM-stage instruction valid, from `out_valid` of the EXU→MEM register.
- `is_load`  in  1  instruction is a load.
- `is_store`  in  1  instruction is a store.
- `is_unsigned`  in  1  load zero-extends when 1, sign-extends when 0.
- `ls_size`  in  4  one-hot access size: 0001=byte, 0010=half, 0100=word, 1000=double. Any non-one-hot value is treated as double.
- `ls_address`  in  64  effective byte address.
- `store_data`  in  64  store source (src2), value in low bits.
- `flush`  in  1  kills the current memory instruction.
- `req_valid`  out  1  cache request valid.
- `req_ready`  in  1  cache accepts request.
- `req_write`  out  1  1 means store.
- `req_addr`  out  64  `ls_address` with bits [2:0] cleared.
- `req_wdata`  out  64  store data shifted into byte lanes.
- `req_wmask`  out  8  byte-lane write enables (0 for loads).
- `resp_valid`  in  1  cache response; one cycle per accepted request.
- `resp_rdata`  in  64  read doubleword (don't-care for stores).
- `mem_stall`  out  1  holds the EXU→MEM register (drives its `stall`).
- `misalign`  out  1  combinational misaligned-access flag.
- `load_data`  out  64  aligned and extended load result, registered.
- `load_data_valid`  out  1  one-cycle pulse in DONE for loads.

## Operation
- State register with four states: IDLE, REQ, WAIT, DONE. Reset puts it in IDLE.
- `mem_op = in_valid & (is_load | is_store)`.
- Misalignment conditions:
  - half access with `addr[0] != 0`
  - word access with `addr[1:0] != 0`
  - double access with `addr[2:0] != 0`
- `misalign = mem_op & misaligned & ~flush` and is only asserted in IDLE. A misaligned instruction issues no request and does not stall.
- IDLE:
  - On `mem_op & ~misaligned & ~flush`: latch the request fields and the load controls (offset = `addr[2:0]`, size, `is_unsigned`, `is_load`), then go to REQ.
  - `req_wdata = store_data << (8*offset)`.
  - `req_wmask = sizemask << offset`, where sizemask is 01, 03, 0F or FF; `req_wmask` = 0 for loads.
- REQ:
  - `req_valid = 1`; fields hold stable until `req_ready`.
  - `flush` with `~req_ready`: go to IDLE and drop `req_valid` next cycle (request never accepted).
  - `req_ready` (with or without `flush`): go to WAIT. The `killed` flag is set equal to `flush`.
- WAIT:
  - `flush` sets `killed`.
  - On `resp_valid`:
    - If `killed`: go to IDLE with no load result.
    - Otherwise: register `load_data` and go to DONE.
  - Load extraction: `sh = resp_rdata >> (8*offset)`, then extend bit 7, 15 or 31 according to size and `is_unsigned`. Double accesses pass through unchanged.
- DONE: `load_data_valid = latched is_load`. Go to IDLE next cycle.
- `mem_stall = (state==REQ) | (state==WAIT) | (state==IDLE & mem_op & ~misaligned & ~flush)`. It is low in DONE, so the EXU→MEM register advances at the end of DONE.
- `resp_valid` arriving in IDLE, REQ or DONE is ignored.
- `flush` in DONE has no effect; the result is already complete.

## Timing
- Reset values:
  - state = IDLE
  - `req_valid` = 0, `req_write` = 0
  - `req_addr`, `req_wdata`, `req_wmask` = 0
  - `load_data` = 0, `load_data_valid` = 0
  - `killed` = 0
- Reset asserted mid-transaction returns to IDLE immediately. A later stale `resp_valid` is ignored.
- Minimum occupancy, with `req_ready = 1` and the response on the cycle after the handshake:
  - cycle 0: IDLE, `mem_stall` = 1
  - cycle 1: REQ, handshake
  - cycle 2: WAIT, `resp_valid`
  - cycle 3: DONE, `load_data_valid`, `mem_stall` = 0
  - The next instruction is visible at cycle 4.
- A response in the same cycle as the request handshake is illegal; the cache never produces one.
- Each `req_ready` wait cycle and each response wait cycle adds one cycle.
- Non-memory valid instructions never stall and pass through in one cycle.

## Test plan
- Load byte `addr=0x1003`, `is_unsigned=0`, `resp_rdata=0x0000_0000_8000_0000` → `req_addr=0x1000`, `req_wmask=0`, `load_data=0xFFFF_FFFF_FFFF_FF80` in DONE at cycle 3, `mem_stall` high for cycles 0–2.
- Store half `addr=0x2006`, `store_data=0xABCD` → `req_write=1`, `req_wdata=0xABCD_0000_0000_0000`, `req_wmask=0xC0`, `load_data_valid` stays 0.
- Load word `addr=0x10` unsigned, `req_ready` low for 3 cycles, `resp_rdata=0x0000_0000_F000_0001` → `req_valid` and fields stable throughout; `load_data=0x0000_0000_F000_0001`, 7 cycles total.
- Load double `addr=0x0C` → `misalign=1` the same cycle, `req_valid=0`, `mem_stall=0`.
- `flush` in WAIT, then `resp_valid` → IDLE, no DONE, `load_data` unchanged. `flush` in REQ with `req_ready=0` → `req_valid` drops the next cycle.
- `reset` asserted in WAIT, then `resp_valid` after release → all outputs at reset values, response ignored.

Source files
------------

// File: rtl/mem_lsu.sv
// ============================================================================
// Module   : mem_lsu
// Purpose  : Memory-stage load/store unit. It issues one cache request per memory
//            instruction and returns the aligned, extended load result.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_lsu #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic                      is_load,
   input  logic                      is_store,
   input  logic                      is_unsigned,
   input  logic [3:0]                ls_size,
   input  logic [DATA_WIDTH-1:0]     ls_address,
   input  logic [DATA_WIDTH-1:0]     store_data,
   input  logic                      flush,
   output logic                      req_valid,
   input  logic                      req_ready,
   output logic                      req_write,
   output logic [DATA_WIDTH-1:0]     req_addr,
   output logic [DATA_WIDTH-1:0]     req_wdata,
   output logic [DATA_WIDTH/8-1:0]   req_wmask,
   input  logic                      resp_valid,
   input  logic [DATA_WIDTH-1:0]     resp_rdata,
   output logic                      mem_stall,
   output logic                      misalign,
   output logic [DATA_WIDTH-1:0]     load_data,
   output logic                      load_data_valid
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                    state_q;
   logic [DATA_WIDTH-1:0]     req_addr_q;
   logic [DATA_WIDTH-1:0]     req_wdata_q;
   logic [DATA_WIDTH/8-1:0]   req_wmask_q;
   logic                      req_write_q;
   logic [2:0]                off_q;
   logic [3:0]                size_q;
   logic                      uns_q;
   logic                      is_load_q;
   logic                      killed_q;
   logic [DATA_WIDTH-1:0]     load_data_q;

   logic [3:0]                size_d;
   logic [7:0]                sizemask_d;
   logic                      misaligned_d;
   logic                      mem_op_d;
   logic                      accept_d;
   logic [DATA_WIDTH-1:0]     shifted_d;
   logic [DATA_WIDTH-1:0]     load_ext_d;

   // Anything that is not a clean one-hot size is handled as a doubleword.
   always_comb begin
      size_d = 4'b1000;
      case (ls_size)
         4'b0001, 4'b0010, 4'b0100: size_d = ls_size;
         default:                   size_d = 4'b1000;
      endcase
   end

   always_comb begin
      sizemask_d = 8'hFF;
      case (size_d)
         4'b0001: sizemask_d = 8'h01;
         4'b0010: sizemask_d = 8'h03;
         4'b0100: sizemask_d = 8'h0F;
         default: sizemask_d = 8'hFF;
      endcase
   end

   assign misaligned_d = (size_d[1] & ls_address[0])
                       | (size_d[2] & (|ls_address[1:0]))
                       | (size_d[3] & (|ls_address[2:0]));
   assign mem_op_d     = in_valid & (is_load | is_store);
   assign accept_d     = (state_q == S_IDLE) & mem_op_d & ~misaligned_d & ~flush;

   assign shifted_d = resp_rdata >> {off_q, 3'b000};

   always_comb begin
      load_ext_d = shifted_d;
      case (size_q)
         4'b0001: load_ext_d = {{(DATA_WIDTH-8){~uns_q & shifted_d[7]}},   shifted_d[7:0]};
         4'b0010: load_ext_d = {{(DATA_WIDTH-16){~uns_q & shifted_d[15]}}, shifted_d[15:0]};
         4'b0100: load_ext_d = {{(DATA_WIDTH-32){~uns_q & shifted_d[31]}}, shifted_d[31:0]};
         default: load_ext_d = shifted_d;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         req_wmask_q <= '0;
         req_write_q <= 1'b0;
         off_q       <= 3'd0;
         size_q      <= 4'b0000;
         uns_q       <= 1'b0;
         is_load_q   <= 1'b0;
         killed_q    <= 1'b0;
         load_data_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_d) begin
                  req_addr_q  <= {ls_address[DATA_WIDTH-1:3], 3'b000};
                  req_wdata_q <= store_data << {ls_address[2:0], 3'b000};
                  req_wmask_q <= is_load ? '0 : (sizemask_d << ls_address[2:0]);
                  req_write_q <= is_store & ~is_load;
                  off_q       <= ls_address[2:0];
                  size_q      <= size_d;
                  uns_q       <= is_unsigned;
                  is_load_q   <= is_load;
                  state_q     <= S_REQ;
               end
            end
            S_REQ: begin
               if (req_ready) begin
                  killed_q <= flush;
                  state_q  <= S_WAIT;
               end else if (flush) begin
                  state_q  <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (flush) killed_q <= 1'b1;
               // A flush coinciding with the response also discards the result.
               if (resp_valid) begin
                  if (killed_q | flush) begin
                     state_q <= S_IDLE;
                  end else begin
                     if (is_load_q) load_data_q <= load_ext_d;
                     state_q <= S_DONE;
                  end
               end
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_valid       = (state_q == S_REQ);
   assign req_write       = req_write_q;
   assign req_addr        = req_addr_q;
   assign req_wdata       = req_wdata_q;
   assign req_wmask       = req_wmask_q;
   assign load_data       = load_data_q;
   assign load_data_valid = (state_q == S_DONE) & is_load_q;
   assign mem_stall       = (state_q == S_REQ) | (state_q == S_WAIT) | accept_d;
   assign misalign        = (state_q == S_IDLE) & mem_op_d & misaligned_d & ~flush;

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ============================================================================
// Module   : tb_mem_lsu
// Purpose  : Self-checking bench for mem_lsu: directed table, hand-written
//            flush/reset sequences and randomized operations against a model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_lsu;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid, is_load, is_store, is_unsigned, flush;
   logic [3:0]  ls_size;
   logic [63:0] ls_address, store_data;
   logic        req_valid, req_ready, req_write;
   logic [63:0] req_addr, req_wdata;
   logic [7:0]  req_wmask;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        mem_stall, misalign;
   logic [63:0] load_data;
   logic        load_data_valid;

   mem_lsu #(.DATA_WIDTH(64)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .is_load(is_load),
      .is_store(is_store), .is_unsigned(is_unsigned), .ls_size(ls_size),
      .ls_address(ls_address), .store_data(store_data), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .mem_stall(mem_stall),
      .misalign(misalign), .load_data(load_data), .load_data_valid(load_data_valid)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        ld, st, uns;
      logic [3:0]  sz;
      logic [63:0] addr, sd, rd;
      int          rdly, pdly;
      logic        e_mis;
      logic [63:0] e_addr, e_wdata;
      logic [7:0]  e_wmask;
      logic [63:0] e_ld;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_ld_reg = 64'd0;
   vec_t        tbl[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic int nbytes(input logic [3:0] sz);
      case (sz)
         4'b0001: return 1;
         4'b0010: return 2;
         4'b0100: return 4;
         default: return 8;
      endcase
   endfunction

   // Reference model: byte-level view of alignment, lane placement and extension.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      int n   = nbytes(v.sz);
      int off = int'(v.addr % 8);
      r.e_mis   = (v.addr % n) != 0;
      r.e_addr  = v.addr - (v.addr % 8);
      r.e_wdata = 64'd0;
      r.e_wmask = 8'd0;
      r.e_ld    = 64'd0;
      for (int b = 0; b < 8; b++) begin
         if (b >= off) r.e_wdata[8*b +: 8] = v.sd[8*(b-off) +: 8];
         if (!v.ld && b >= off && b < off + n) r.e_wmask[b] = 1'b1;
      end
      for (int b = 0; b < 8; b++) begin
         if (b < n && off + b < 8) r.e_ld[8*b +: 8] = v.rd[8*(off+b) +: 8];
         else if (!v.uns && r.e_ld[8*n-1]) r.e_ld[8*b +: 8] = 8'hFF;
      end
      return r;
   endfunction

   function automatic vec_t tv(input logic ld, st, uns, input logic [3:0] sz,
                               input logic [63:0] addr, sd, rd, input int rdly, pdly,
                               input logic mis, input logic [63:0] ea, ew,
                               input logic [7:0] em, input logic [63:0] el);
      vec_t v;
      v.ld = ld; v.st = st; v.uns = uns; v.sz = sz; v.addr = addr; v.sd = sd; v.rd = rd;
      v.rdly = rdly; v.pdly = pdly; v.e_mis = mis; v.e_addr = ea; v.e_wdata = ew;
      v.e_wmask = em; v.e_ld = el;
      return v;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 0; is_load = 0; is_store = 0; is_unsigned = 0; flush = 0;
      ls_size = 4'b0001; ls_address = '0; store_data = '0;
   endtask

   task automatic drive(input vec_t v);
      in_valid = 1; is_load = v.ld; is_store = v.st; is_unsigned = v.uns;
      ls_size = v.sz; ls_address = v.addr; store_data = v.sd;
   endtask

   task automatic req_checks(input vec_t v, input string tag);
      chk({tag, " req_valid"}, 64'(req_valid), 64'd1);
      chk({tag, " req_addr"},  req_addr, v.e_addr);
      chk({tag, " req_wdata"}, req_wdata, v.e_wdata);
      chk({tag, " req_wmask"}, 64'(req_wmask), 64'(v.e_wmask));
      chk({tag, " req_write"}, 64'(req_write), 64'(v.st));
      chk({tag, " stall_req"}, 64'(mem_stall), 64'd1);
   endtask

   // Runs one full instruction; caller is positioned just after a rising edge.
   task automatic do_op(input vec_t v, input string tag);
      drive(v);
      @(negedge clock);
      chk({tag, " misalign"}, 64'(misalign), 64'(v.e_mis));
      chk({tag, " stall0"}, 64'(mem_stall), 64'(!v.e_mis));
      if (v.e_mis) begin
         chk({tag, " req_valid0"}, 64'(req_valid), 64'd0);
         step();
         idle_inputs();
         return;
      end
      step();
      for (int k = 0; k < v.rdly; k++) begin
         @(negedge clock);
         req_checks(v, tag);
         step();
      end
      req_ready = 1;
      @(negedge clock);
      req_checks(v, tag);
      step();
      req_ready = 0;
      for (int k = 0; k < v.pdly; k++) begin
         @(negedge clock);
         chk({tag, " stall_wait"}, 64'(mem_stall), 64'd1);
         chk({tag, " ldv_wait"}, 64'(load_data_valid), 64'd0);
         step();
      end
      resp_valid = 1;
      resp_rdata = v.rd;
      @(negedge clock);
      chk({tag, " stall_resp"}, 64'(mem_stall), 64'd1);
      step();
      resp_valid = 0;
      resp_rdata = $urandom();
      @(negedge clock);
      chk({tag, " stall_done"}, 64'(mem_stall), 64'd0);
      chk({tag, " ldv_done"}, 64'(load_data_valid), 64'(v.ld));
      if (v.ld) begin
         chk({tag, " load_data"}, load_data, v.e_ld);
         exp_ld_reg = v.e_ld;
      end
      step();
      idle_inputs();
   endtask

   task automatic to_wait(input vec_t v);
      drive(v);
      step();
      req_ready = 1;
      step();
      req_ready = 0;
   endtask

   initial begin
      vec_t v;
      idle_inputs();
      reset = 1; req_ready = 0; resp_valid = 0; resp_rdata = '0;

      tbl[0]  = tv(1,0,0,4'b0001,64'h1003,0,64'h8000_0000,0,0, 0,64'h1000,0,8'h00,64'hFFFF_FFFF_FFFF_FF80);
      tbl[1]  = tv(0,1,0,4'b0010,64'h2006,64'hABCD,0,0,0, 0,64'h2000,64'hABCD_0000_0000_0000,8'hC0,0);
      tbl[2]  = tv(1,0,1,4'b0100,64'h10,0,64'hF000_0001,3,0, 0,64'h10,0,8'h00,64'h0000_0000_F000_0001);
      tbl[3]  = tv(1,0,0,4'b1000,64'h0C,0,0,0,0, 1,0,0,8'h00,0);
      tbl[4]  = tv(1,0,0,4'b0100,64'h14,0,64'h8000_0001_0000_0000,1,1, 0,64'h10,0,8'h00,64'hFFFF_FFFF_8000_0001);
      tbl[5]  = tv(0,1,0,4'b0001,64'h7,64'h5A,0,0,2, 0,64'h0,64'h5A00_0000_0000_0000,8'h80,0);
      tbl[6]  = tv(1,0,0,4'b0010,64'h3,0,0,0,0, 1,0,0,8'h00,0);
      tbl[7]  = tv(1,0,1,4'b0010,64'h2,0,64'h8765_0000,0,0, 0,64'h0,0,8'h00,64'h8765);
      tbl[8]  = tv(1,0,0,4'b1000,64'h18,0,64'h0123_4567_89AB_CDEF,0,2, 0,64'h18,0,8'h00,64'h0123_4567_89AB_CDEF);
      tbl[9]  = tv(0,1,0,4'b0011,64'h20,64'h1122_3344_5566_7788,0,1,0, 0,64'h20,64'h1122_3344_5566_7788,8'hFF,0);
      tbl[10] = tv(0,1,0,4'b0011,64'h24,64'h1,0,0,0, 1,0,0,8'h00,0);

      @(negedge clock);
      chk("rst req_valid", 64'(req_valid), 64'd0);
      chk("rst req_write", 64'(req_write), 64'd0);
      chk("rst req_addr",  req_addr, 64'd0);
      chk("rst req_wdata", req_wdata, 64'd0);
      chk("rst req_wmask", 64'(req_wmask), 64'd0);
      chk("rst load_data", load_data, 64'd0);
      chk("rst ldv",       64'(load_data_valid), 64'd0);
      step();
      reset = 0;
      step();

      for (int i = 0; i < 11; i++) do_op(tbl[i], $sformatf("tbl%0d", i));

      // Non-memory instruction passes without stalling.
      in_valid = 1; is_load = 0; is_store = 0; ls_address = 64'h3;
      @(negedge clock);
      chk("nonmem stall", 64'(mem_stall), 64'd0);
      chk("nonmem misalign", 64'(misalign), 64'd0);
      step();
      idle_inputs();
      @(negedge clock);
      chk("nonmem req_valid", 64'(req_valid), 64'd0);
      step();

      // Flush while waiting for the response: result discarded.
      do_op(tbl[0], "pre_flush");
      to_wait(tbl[7]);
      flush = 1; in_valid = 0;
      @(negedge clock);
      chk("flw stall", 64'(mem_stall), 64'd1);
      step();
      flush = 0;
      resp_valid = 1; resp_rdata = 64'h1234_5678_9ABC_DEF0;
      @(negedge clock);
      chk("flw stall_resp", 64'(mem_stall), 64'd1);
      step();
      resp_valid = 0;
      @(negedge clock);
      chk("flw ldv", 64'(load_data_valid), 64'd0);
      chk("flw load_data", load_data, exp_ld_reg);
      chk("flw stall_after", 64'(mem_stall), 64'd0);
      chk("flw req_valid", 64'(req_valid), 64'd0);
      step();

      // Flush in REQ while the cache is not ready: request withdrawn.
      drive(tbl[1]);
      step();
      flush = 1; in_valid = 0;
      @(negedge clock);
      chk("flr req_valid", 64'(req_valid), 64'd1);
      step();
      flush = 0;
      @(negedge clock);
      chk("flr req_valid_drop", 64'(req_valid), 64'd0);
      chk("flr stall", 64'(mem_stall), 64'd0);
      step();
      do_op(tbl[8], "post_flush");

      // Reset during WAIT; a stale response afterwards must be ignored.
      v = model(tv(0,1,0,4'b0100,64'h2004,64'hDEAD_BEEF,0,0,0, 0,0,0,0,0));
      to_wait(v);
      reset = 1; in_valid = 0;
      #1;
      chk("rw req_valid", 64'(req_valid), 64'd0);
      chk("rw req_addr",  req_addr, 64'd0);
      chk("rw req_wdata", req_wdata, 64'd0);
      chk("rw req_wmask", 64'(req_wmask), 64'd0);
      chk("rw req_write", 64'(req_write), 64'd0);
      chk("rw load_data", load_data, 64'd0);
      chk("rw stall",     64'(mem_stall), 64'd0);
      step();
      reset = 0;
      exp_ld_reg = 64'd0;
      resp_valid = 1; resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      resp_valid = 0;
      @(negedge clock);
      chk("rw stale ldv", 64'(load_data_valid), 64'd0);
      chk("rw stale load_data", load_data, 64'd0);
      chk("rw stale req_valid", 64'(req_valid), 64'd0);
      chk("rw stale stall", 64'(mem_stall), 64'd0);
      step();

      for (int i = 0; i < 60; i++) begin
         logic [3:0] szs [5];
         szs[0] = 4'b0001; szs[1] = 4'b0010; szs[2] = 4'b0100; szs[3] = 4'b1000;
         szs[4] = 4'($urandom_range(0, 15));
         v.ld   = 1'($urandom_range(0, 1));
         v.st   = !v.ld;
         v.uns  = 1'($urandom_range(0, 1));
         v.sz   = szs[$urandom_range(0, 4)];
         v.addr = {$urandom(), $urandom()};
         if ($urandom_range(0, 2) != 0) v.addr = v.addr - (v.addr % 64'(nbytes(v.sz)));
         v.sd   = {$urandom(), $urandom()};
         v.rd   = {$urandom(), $urandom()};
         v.rdly = $urandom_range(0, 3);
         v.pdly = $urandom_range(0, 3);
         do_op(model(v), $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
